// File: rtl/io_response_encoder_pkg.sv
// Shared code constants and encoder state encoding for the board/PC link.
// Both directions of the protocol live here so every block agrees on the byte values.
package io_response_encoder_pkg;

    // PC-to-board requests
    localparam logic [7:0] CMD_GET_INFO  = 8'd0;
    localparam logic [7:0] CMD_RESET     = 8'd1;
    localparam logic [7:0] CMD_CONFIGURE = 8'd2;
    localparam logic [7:0] CMD_START     = 8'd3;
    localparam logic [7:0] CMD_READ      = 8'd4;
    localparam logic [7:0] CMD_WRITE     = 8'd5;

    // Board-to-PC responses
    localparam logic [7:0] RSP_SEND_INFO     = 8'd0;
    localparam logic [7:0] RSP_RESETED       = 8'd1;
    localparam logic [7:0] RSP_CONF_RECEIVED = 8'd2;
    localparam logic [7:0] RSP_STARTED       = 8'd3;
    localparam logic [7:0] RSP_REQ_DATA      = 8'd4;
    localparam logic [7:0] RSP_SEND_DATA     = 8'd5;
    localparam logic [7:0] RSP_DONE_RD       = 8'd6;
    localparam logic [7:0] RSP_DONE_WR       = 8'd7;
    localparam logic [7:0] RSP_DONE_ACC      = 8'd8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_TRIG    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;

    function automatic logic is_legal_rsp(input logic [7:0] code);
        return code <= RSP_DONE_ACC;
    endfunction

endpackage

// File: rtl/io_response_encoder.sv
// Serialises one board-to-PC response frame into bytes for the UART transmitter,
// handshaking each byte through the transmitter's busy flag.
module io_response_encoder
    import io_response_encoder_pkg::*;
#(
    parameter logic [7:0] INFO_TO_SEND = 8'd1,
    parameter int         LEN_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_code,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic                pl_valid,
    output logic                pl_ready,
    input  logic [7:0]          pl_data,
    output logic                send_trig,
    output logic [7:0]          send_data,
    input  logic                tx_bsy,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         frame_cnt
);

    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

    logic [2:0]          state;
    logic [7:0]          code_q;
    logic [LEN_BITS-1:0] remaining;
    logic                second_stage;
    logic                frame_last;

    // Only SEND_INFO and SEND_DATA carry a second byte; SEND_DATA then drains its payload.
    always_comb begin
        frame_last = 1'b0;
        if (!second_stage)
            frame_last = (code_q != RSP_SEND_INFO) && (code_q != RSP_SEND_DATA);
        else
            frame_last = (code_q != RSP_SEND_DATA) || (remaining == '0);
    end

    assign cmd_ready = !rst && (state == ST_IDLE);
    assign pl_ready  = !rst && (state == ST_FETCH);
    assign send_trig = !rst && (state == ST_TRIG) && !tx_bsy;
    assign busy      = !rst && (state != ST_IDLE);
    assign done      = !rst && (state == ST_NEXT) && frame_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            code_q       <= 8'h00;
            remaining    <= '0;
            second_stage <= 1'b0;
            send_data    <= 8'h00;
            err          <= 1'b0;
            frame_cnt    <= 16'h0000;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        code_q    <= cmd_code;
                        remaining <= cmd_len;
                        if (!is_legal_rsp(cmd_code)) begin
                            err <= 1'b1;
                        end else begin
                            send_data    <= cmd_code;
                            second_stage <= 1'b0;
                            state        <= ST_TRIG;
                        end
                    end
                end
                ST_FETCH: begin
                    if (pl_valid) begin
                        send_data <= pl_data;
                        remaining <= remaining - LEN_ONE;
                        state     <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (!tx_bsy)
                        state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_bsy)
                        state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!tx_bsy)
                        state <= ST_NEXT;
                end
                ST_NEXT: begin
                    // The length byte is the untouched latched count, sent before any payload.
                    if (frame_last) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= ST_IDLE;
                    end else if (!second_stage) begin
                        second_stage <= 1'b1;
                        send_data    <= (code_q == RSP_SEND_INFO) ? INFO_TO_SEND : 8'(remaining);
                        state        <= ST_TRIG;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_response_encoder.sv
// Bench for io_response_encoder: UART transmitter model, frame-level reference model
// with a per-cycle compare process, and directed frames with literal expectations.
module tb_io_response_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        send_trig;
    logic [7:0]  send_data;
    logic        tx_bsy;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] sent_log[$];
    logic [7:0] ref_log[$];
    logic [7:0] pl_src[$];

    bit         active = 0;
    bit         acc_now = 0;
    bit         hs_now = 0;
    bit         err_m = 0;
    int         pay_left = 0;
    int         frame_cnt_m = 0;
    logic [7:0] last_trig = 8'h00;
    int         cycle = 0;
    int         last_done_cycle = -100;
    int         done_count = 0;
    int         err_seen = 0;
    int         pl_gap = 10;
    int         tx_cnt = 0;

    io_response_encoder #(.INFO_TO_SEND(8'h01), .LEN_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .send_trig(send_trig), .send_data(send_data), .tx_bsy(tx_bsy),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Transmitter stand-in: busy one cycle after the strobe, for 90 cycles.
    always @(posedge clk) begin
        if (rst) begin
            tx_bsy <= 1'b0;
            tx_cnt <= 0;
        end else if (send_trig) begin
            tx_bsy <= 1'b1;
            tx_cnt <= 90;
        end else if (tx_bsy) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1)
                tx_bsy <= 1'b0;
        end
    end

    // Frame-level model: expected byte list per accepted request, payload appended as consumed.
    always @(posedge clk) begin
        bit was_active;
        cycle++;
        hs_now  = 0;
        acc_now = 0;
        if (rst) begin
            active = 0;
            exp_q.delete();
            pay_left = 0;
            err_m = 0;
            frame_cnt_m = 0;
        end else begin
            was_active = active;
            err_m = 0;
            if (send_trig) begin
                check_output($sformatf("done_to_trig_spacing_%0d", cycle - last_done_cycle),
                             32'(cycle - last_done_cycle >= 2), 32'd1);
                if (exp_q.size() > 0)
                    void'(exp_q.pop_front());
                sent_log.push_back(send_data);
                last_trig = send_data;
            end
            if (pl_valid && pl_ready) begin
                hs_now = 1;
                exp_q.push_back(pl_data);
                pay_left--;
            end
            if (done) begin
                active = 0;
                frame_cnt_m = (frame_cnt_m + 1) % 65536;
                done_count++;
                last_done_cycle = cycle;
            end
            if (!was_active && cmd_valid) begin
                acc_now = 1;
                if (cmd_code > 8) begin
                    err_m = 1;
                end else begin
                    active = 1;
                    exp_q.delete();
                    exp_q.push_back(cmd_code);
                    pay_left = 0;
                    if (cmd_code == 8'd0)
                        exp_q.push_back(8'h01);
                    if (cmd_code == 8'd5) begin
                        exp_q.push_back(cmd_len);
                        pay_left = int'(cmd_len);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check_output("cmd_ready", cmd_ready, 32'(!rst && !active));
        check_output("busy", busy, 32'(!rst && active));
        check_output("err", err, 32'(err_m));
        check_output("frame_cnt", frame_cnt, 32'(frame_cnt_m));
        if (err === 1'b1)
            err_seen++;
        if (rst) begin
            check_output("rst_send_trig", send_trig, 32'd0);
            check_output("rst_pl_ready", pl_ready, 32'd0);
            check_output("rst_done", done, 32'd0);
        end else begin
            if (send_trig) begin
                check_output("trig_expected", 32'(active && exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check_output("trig_byte", send_data, exp_q[0]);
                check_output("trig_tx_idle", tx_bsy, 32'd0);
            end
            if (pl_ready)
                check_output("pl_ready_needed", 32'(active && pay_left > 0 && exp_q.size() == 0), 32'd1);
            if (done)
                check_output("done_frame_complete",
                             32'(active && exp_q.size() == 0 && pay_left == 0 && !tx_bsy), 32'd1);
            if (tx_bsy)
                check_output("send_data_stable", send_data, last_trig);
        end
    end

    // Payload source: presents queued bytes, idling pl_gap cycles before each one.
    initial begin
        int gap;
        gap = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                pl_valid = 1'b0;
                pl_src.delete();
                gap = 0;
            end else begin
                if (pl_valid && hs_now) begin
                    pl_valid = 1'b0;
                    gap = 0;
                end
                if (!pl_valid && pl_src.size() > 0) begin
                    if (gap >= pl_gap) begin
                        pl_valid = 1'b1;
                        pl_data  = pl_src.pop_front();
                    end else begin
                        gap++;
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] code, input logic [7:0] len);
        bit accepted;
        accepted = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_len   = len;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (acc_now) begin
                accepted = 1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check_output($sformatf("accept_code_%0h", code), 32'(accepted), 32'd1);
    endtask

    task automatic wait_frame_done(input int budget);
        int start;
        bit seen;
        start = done_count;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_count > start) begin
                seen = 1;
                break;
            end
        end
        check_output("frame_done_within_budget", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag);
        int n;
        check_output({tag, "_len"}, sent_log.size(), ref_log.size());
        n = (sent_log.size() < ref_log.size()) ? sent_log.size() : ref_log.size();
        for (int i = 0; i < n; i++)
            check_output($sformatf("%s_byte%0d", tag, i), sent_log[i], ref_log[i]);
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_done;
        int base_err;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 8'h00;
        cmd_len   = 8'h00;
        pl_valid  = 1'b0;
        pl_data   = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_cmd_ready", cmd_ready, 32'd0);
        check_output("reset_send_data", send_data, 32'h00);
        check_output("reset_frame_cnt", frame_cnt, 32'd0);
        check_output("reset_busy", busy, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] STARTED frame");
        sent_log.delete();
        apply_stimulus(8'd3, 8'd0);
        wait_frame_done(1000);
        ref_log = '{8'h03};
        check_log("started");
        check_output("started_frame_cnt", frame_cnt, 32'd1);

        $display("[TB] SEND_INFO frame");
        sent_log.delete();
        apply_stimulus(8'd0, 8'd0);
        wait_frame_done(1000);
        ref_log = '{8'h00, 8'h01};
        check_log("info");
        check_output("info_frame_cnt", frame_cnt, 32'd2);

        $display("[TB] SEND_DATA len=3 with gaps");
        sent_log.delete();
        pl_gap = 10;
        pl_src = '{8'hA5, 8'h5A, 8'hFF};
        apply_stimulus(8'd5, 8'd3);
        wait_frame_done(2000);
        ref_log = '{8'h05, 8'h03, 8'hA5, 8'h5A, 8'hFF};
        check_log("data3");
        check_output("data3_frame_cnt", frame_cnt, 32'd3);

        $display("[TB] illegal code 9");
        sent_log.delete();
        base_err = err_seen;
        apply_stimulus(8'h09, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        check_output("illegal_err_pulses", 32'(err_seen - base_err), 32'd1);
        check_output("illegal_no_trig", sent_log.size(), 32'd0);
        check_output("illegal_frame_cnt", frame_cnt, 32'd3);

        $display("[TB] SEND_DATA len=0");
        sent_log.delete();
        apply_stimulus(8'd5, 8'd0);
        wait_frame_done(1000);
        ref_log = '{8'h05, 8'h00};
        check_log("data0");
        check_output("data0_frame_cnt", frame_cnt, 32'd4);

        $display("[TB] SEND_DATA len=255");
        sent_log.delete();
        pl_gap = 0;
        ref_log.delete();
        ref_log.push_back(8'h05);
        ref_log.push_back(8'hFF);
        for (int i = 0; i < 255; i++) begin
            pl_src.push_back(8'(i) ^ 8'h3C);
            ref_log.push_back(8'(i) ^ 8'h3C);
        end
        apply_stimulus(8'd5, 8'hFF);
        wait_frame_done(40000);
        check_log("data255");
        check_output("data255_frame_cnt", frame_cnt, 32'd5);

        $display("[TB] reset during SEND_DATA len=4");
        sent_log.delete();
        pl_gap = 10;
        pl_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        base_done = done_count;
        apply_stimulus(8'd5, 8'd4);
        for (int i = 0; i < 1000 && sent_log.size() < 4; i++)
            @(posedge clk);
        check_output("midreset_reached_byte2", 32'(sent_log.size() >= 4), 32'd1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("midreset_busy", busy, 32'd0);
        check_output("midreset_send_data", send_data, 32'h00);
        check_output("midreset_send_trig", send_trig, 32'd0);
        check_output("midreset_frame_cnt", frame_cnt, 32'd0);
        check_output("midreset_err", err, 32'd0);
        repeat (100) @(posedge clk);
        check_output("midreset_no_done", 32'(done_count - base_done), 32'd0);

        sent_log.delete();
        apply_stimulus(8'd1, 8'd0);
        wait_frame_done(1000);
        ref_log = '{8'h01};
        check_log("reseted");
        check_output("reseted_frame_cnt", frame_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_response_encoder.md
IO_RESPONSE_ENCODER -- requirements
Module: io_response_encoder

Interface
REQ-001 Parameter INFO_TO_SEND, default 8'd1, info byte returned in SEND_INFO frames (channel count).
REQ-002 Parameter LEN_BITS, default 8, width of payload length field.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  response request present.
REQ-006 cmd_ready  output  1  encoder accepts request this cycle.
REQ-007 cmd_code  input  8  board-to-PC code: SEND_INFO=0, RESETED=1, CONF_RECEIVED=2, STARTED=3, REQ_DATA=4, SEND_DATA=5, DONE_RD=6, DONE_WR=7, DONE_ACC=8.
REQ-008 cmd_len  input  LEN_BITS  payload byte count, used only for SEND_DATA.
REQ-009 pl_valid  input  1  payload byte available.
REQ-010 pl_ready  output  1  payload byte consumed this cycle.
REQ-011 pl_data  input  8  payload byte.
REQ-012 send_trig  output  1  start-frame strobe to UART transmitter.
REQ-013 send_data  output  8  byte to UART transmitter.
REQ-014 tx_bsy  input  1  UART transmitter busy.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse when a frame's last byte finishes.
REQ-017 err  output  1  one-cycle pulse when an illegal code is rejected.
REQ-018 frame_cnt  output  16  count of completed frames, wraps 16'hFFFF->0.

Function
REQ-019 Frame bytes: always cmd_code first; SEND_INFO appends INFO_TO_SEND; SEND_DATA appends cmd_len byte then cmd_len payload bytes; all other legal codes send the code byte only.
REQ-020 States: IDLE, FETCH, TRIG, WAIT_HI, WAIT_LO, NEXT.
REQ-021 IDLE: cmd_ready=1; on cmd_valid latch code and len; code>8 -> err pulse next cycle, stay IDLE; else load code byte, go TRIG.
REQ-022 TRIG: when tx_bsy=0 assert send_trig for exactly one cycle, go WAIT_HI; when tx_bsy=1 wait in TRIG.
REQ-023 WAIT_HI: wait for tx_bsy=1, then WAIT_LO; WAIT_LO: wait for tx_bsy=0, then NEXT.
REQ-024 send_data SHALL stay stable from TRIG entry until WAIT_LO exit (transmitter samples it every cycle).
REQ-025 NEXT: select next byte per REQ-019; payload byte -> FETCH; fixed byte -> TRIG; no bytes left -> done pulse, frame_cnt+1, IDLE.
REQ-026 FETCH: pl_ready=1 while in FETCH; on pl_valid&pl_ready capture pl_data into send_data, decrement remaining count, go TRIG; pl_valid low -> hold indefinitely.
REQ-027 cmd_len=0 with SEND_DATA: frame is code byte plus length byte 0, no FETCH entered.
REQ-028 cmd_len=2^LEN_BITS-1: exactly that many payload bytes, counter must not wrap.
REQ-029 cmd_ready=0 and pl_ready=0 outside IDLE and FETCH respectively; new requests are back-pressured, never dropped.
REQ-030 Minimum spacing: done to next send_trig >= 2 cycles (IDLE accept plus TRIG).

Reset
REQ-031 On rst: state IDLE, send_trig=0, send_data=8'h00, cmd_ready=0 in the reset cycle, pl_ready=0, busy=0, done=0, err=0, frame_cnt=0.
REQ-032 rst mid-frame abandons the frame; no done pulse, frame_cnt not incremented; no send_trig in first cycle after reset.

Structure
REQ-033 Shared package holds the PC-to-board and board-to-PC code constants and the encoder state encoding (3-bit).
REQ-034 No sub-module; UART transmitter instantiated by the parent, connected via send_trig/send_data/tx_bsy.

Verification
REQ-035 Bench uses a UART transmitter model: tx_bsy rises 1 cycle after send_trig, falls 90 cycles later.
REQ-036 cmd_code=3 -> one send_trig, send_data=8'h03, done after tx_bsy falls, frame_cnt=1.
REQ-037 cmd_code=0, INFO_TO_SEND=8'h01 -> bytes 8'h00, 8'h01 in order, one done.
REQ-038 cmd_code=5, cmd_len=3, payload A5,5A,FF with pl_valid gaps of 10 cycles -> bytes 05,03,A5,5A,FF; send_data stable during each tx_bsy window.
REQ-039 cmd_code=8'h09 -> err pulse, no send_trig, busy stays 0, frame_cnt unchanged.
REQ-040 rst asserted during payload byte 2 of SEND_DATA len=4 -> all outputs reset values next cycle, no done; subsequent cmd_code=1 frame transmits 8'h01 correctly.
